tpu_stream: RTL and testbench

Parametrised successor to the current TPU top. Accepts a job as a single handshaked word stream: matrix A (N x K), then matrix B (K x M). Computes C = A*B, or C += A*B, on an N x M grid of MAC accumulators. Streams C out with valid/ready backpressure. Adds element width, inner dimension K, signed/unsigned mode, accumulate-across-jobs (K-tiling) and out_last framing.

---
 rtl/tpu_stream.sv | 228 ++++++++++++++++++++++
 tb/tb_tpu_stream.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_stream.sv
// tpu_stream: streamed N x M matrix-multiply tile computing C = A*B or C += A*B.
// Build option: define TPU_SAT_EN for saturating accumulation (default wraps modulo 2^ACC_W).
module tpu_stream #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int N      = 4,
  parameter int M      = 4,
  parameter int K      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_mode,
  input  logic              acc_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NK     = N * K;
  localparam int KM     = K * M;
  localparam int NM     = N * M;
  localparam int IN_MAX = (NK > KM) ? NK : KM;
  localparam int IN_W   = $clog2(IN_MAX + 1);
  localparam int K_W    = $clog2(K + 1);
  localparam int IDX_W  = $clog2(NM + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [IN_W-1:0]    in_cnt_r;
  logic [K_W-1:0]     k_cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   idx_next_s;
  logic               signed_r;
  logic               in_fire_s;
  logic               out_fire_s;
  logic               load_a_end_s;
  logic               load_b_end_s;

  logic [DATA_W-1:0]  a_mem [NK];
  logic [DATA_W-1:0]  b_mem [KM];
  logic [ACC_W-1:0]   acc_r [NM];

  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] x, input logic sgn);
    ext = {{(ACC_W-DATA_W){sgn & x[DATA_W-1]}}, x};
  endfunction

  // One multiply-accumulate step; the product always fits in ACC_W because ACC_W >= 2*DATA_W.
  function automatic logic [ACC_W-1:0] mac_step(input logic [ACC_W-1:0] acc,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic sgn);
    logic [ACC_W-1:0] prod;
`ifdef TPU_SAT_EN
    logic [ACC_W:0]   sum;
`endif
    prod = ext(a, sgn) * ext(b, sgn);
`ifdef TPU_SAT_EN
    sum = {1'b0, acc} + {1'b0, prod};
    if (sgn) begin
      if ((acc[ACC_W-1] == prod[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1])) begin
        mac_step = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        mac_step = sum[ACC_W-1:0];
      end
    end else if (sum[ACC_W]) begin
      mac_step = {ACC_W{1'b1}};
    end else begin
      mac_step = sum[ACC_W-1:0];
    end
`else
    mac_step = acc + prod;
`endif
  endfunction

  assign in_fire_s    = in_valid & in_ready;
  assign out_fire_s   = out_valid & out_ready;
  assign load_a_end_s = in_fire_s && (in_cnt_r == IN_W'(NK - 1));
  assign load_b_end_s = in_fire_s && (in_cnt_r == IN_W'(KM - 1));
  assign idx_next_s   = idx_r + IDX_W'(1);

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = LOAD_A;
        else       state_next_s = IDLE;
      end
      LOAD_A: begin
        if (load_a_end_s) state_next_s = LOAD_B;
        else              state_next_s = LOAD_A;
      end
      LOAD_B: begin
        if (load_b_end_s) state_next_s = COMPUTE;
        else              state_next_s = LOAD_B;
      end
      COMPUTE: begin
        if (k_cnt_r == K_W'(K - 1)) state_next_s = DRAIN;
        else                        state_next_s = COMPUTE;
      end
      DRAIN: begin
        if (out_fire_s && out_last) state_next_s = IDLE;
        else                        state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_next_s;
  end

  // Registered status outputs, derived from the next state so they track the state exactly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= 1'b0;
      in_ready <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy     <= (state_next_s != IDLE);
      in_ready <= (state_next_s == LOAD_A) || (state_next_s == LOAD_B);
      err      <= start && (state_r != IDLE);
      done     <= (state_r == DRAIN) && out_fire_s && out_last;
    end
  end

  // Load and compute counters, plus the per-job signedness latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_cnt_r <= '0;
      k_cnt_r  <= '0;
      signed_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          in_cnt_r <= '0;
          k_cnt_r  <= '0;
          if (start) signed_r <= signed_mode;
        end
        LOAD_A: begin
          if (in_fire_s) in_cnt_r <= load_a_end_s ? '0 : in_cnt_r + IN_W'(1);
        end
        LOAD_B: begin
          if (in_fire_s) in_cnt_r <= load_b_end_s ? '0 : in_cnt_r + IN_W'(1);
        end
        COMPUTE: k_cnt_r <= k_cnt_r + K_W'(1);
        default: begin
          in_cnt_r <= '0;
          k_cnt_r  <= '0;
        end
      endcase
    end
  end

  // Operand storage; contents are only meaningful after a complete load.
  always_ff @(posedge clk) begin
    if (state_r == LOAD_A && in_fire_s) a_mem[int'(in_cnt_r)] <= in_data;
    if (state_r == LOAD_B && in_fire_s) b_mem[int'(in_cnt_r)] <= in_data;
  end

  // Accumulator grid: cleared on reset or a fresh job, one rank-1 update per COMPUTE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int e = 0; e < NM; e++) acc_r[e] <= '0;
    end else if (state_r == IDLE && start && !acc_mode) begin
      for (int e = 0; e < NM; e++) acc_r[e] <= '0;
    end else if (state_r == COMPUTE) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < M; j++) begin
          acc_r[i*M+j] <= mac_step(acc_r[i*M+j], a_mem[i*K+int'(k_cnt_r)],
                                   b_mem[int'(k_cnt_r)*M+j], signed_r);
        end
      end
    end
  end

  // Output stage: the register holds element idx until it is accepted downstream.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      idx_r     <= '0;
    end else begin
      case (state_r)
        DRAIN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= acc_r[int'(idx_r)];
            out_last  <= (idx_r == IDX_W'(NM - 1));
          end else if (out_ready && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (out_ready) begin
            idx_r     <= idx_next_s;
            out_data  <= acc_r[int'(idx_next_s)];
            out_last  <= (idx_next_s == IDX_W'(NM - 1));
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          idx_r     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_stream.sv
// Self-checking bench for tpu_stream: matrix-level reference model plus scoreboard monitor.
module tb_tpu_stream;
  localparam int N = 4, M = 4, K = 4, NK = 16, KM = 16, NM = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, signed_mode = 1'b0, acc_mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic in_ready, out_valid, out_last, busy, done, err;
  logic [31:0] out_data;

  logic start2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic [7:0] in_data2 = 8'd0;
  logic in_ready2, out_valid2, out_last2, busy2, done2, err2;
  logic [15:0] out_data2;

  int checks = 0, errors = 0;
  int cyc = 0, last_b_cyc = 0, out_cnt = 0, err_count = 0;
  bit first_seen, done_seen, exp_done, exp_err, holding, out_rand;
  logic [31:0] hold_data;
  logic hold_last;
  logic [7:0] words [32];
  logic [31:0] model_acc [NM];
  logic [31:0] exp_q [$];

  tpu_stream dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .acc_mode(acc_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
    .done(done), .err(err)
  );

  tpu_stream #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(1'b1), .acc_mode(1'b0),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2), .busy(busy2),
    .done(done2), .err(err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint mext(input logic [7:0] x, input bit s);
    return s ? longint'($signed(x)) : longint'(x);
  endfunction

  // Reference: C (+)= A*B on whole matrices, 32-bit wrap, then queue C row-major.
  task automatic model_launch(input bit sgn, input bit accm);
    if (!accm) for (int e = 0; e < NM; e++) model_acc[e] = 32'd0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        for (int k = 0; k < K; k++)
          model_acc[i*M+j] = model_acc[i*M+j]
                           + 32'(mext(words[i*K+k], sgn) * mext(words[NK+k*M+j], sgn));
    for (int e = 0; e < NM; e++) exp_q.push_back(model_acc[e]);
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) words[i*K+k] = (i == k) ? 8'd1 : 8'd0;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < M; j++) words[NK+k*M+j] = 8'(4*k + j);
  endtask

  task automatic set_const(input logic [7:0] a, input logic [7:0] b);
    for (int e = 0; e < NK; e++) words[e] = a;
    for (int e = 0; e < KM; e++) words[NK+e] = b;
  endtask

  task automatic run_job(input bit sgn, input bit accm, input bit stall, input int err_at,
                         input int rst_after);
    int w, g;
    bit fire, pulsed;
    model_launch(sgn, accm);
    first_seen = 0; done_seen = 0; out_cnt = 0; err_count = 0; pulsed = 0;
    @(posedge clk); #1;
    start = 1'b1; signed_mode = sgn; acc_mode = accm; in_valid = 1'b1; in_data = 8'hAA;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; signed_mode = ~sgn; acc_mode = ~accm;
    w = 0; g = 0;
    while (w < NK + KM && g < 1000) begin
      in_valid = (stall && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      in_data = words[w];
      start = (w == err_at && !pulsed) ? 1'b1 : 1'b0;
      if (start) pulsed = 1;
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) begin
        w++;
        if (w == NK + KM) last_b_cyc = cyc;
      end
      g++;
    end
    start = 1'b0; in_valid = 1'b0;
    if (w != NK + KM) check("load_timeout", 64'(w), 64'(NK + KM));
    g = 0;
    while (!done_seen && !(rst_after > 0 && out_cnt >= rst_after) && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 500) check("drain_timeout", 64'(g), 64'd0);
    if (rst_after == 0) begin
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("out_count", 64'(out_cnt), 64'(NM));
    end
  endtask

  // Downstream ready: random when out_rand is set, otherwise always accepting.
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = out_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: scoreboard, framing, stall stability, latency, done and err pulses.
  always @(negedge clk) begin
    if (!rst) begin
      holding = 0; exp_done = 0; exp_err = 0;
    end else begin
      check("done", done, exp_done);
      if (done) done_seen = 1;
      exp_done = 0;
      check("err", err, exp_err);
      if (err) err_count++;
      exp_err = start && busy;
      if (holding) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, hold_data);
        check("hold_last", out_last, hold_last);
      end
      holding = 0;
      if (out_valid) begin
        if (!first_seen) begin
          check("latency", 64'(cyc - last_b_cyc), 64'(K + 1));
          first_seen = 1;
        end
        if (out_ready) begin
          if (exp_q.size() == 0) check("unexpected_out", out_data, 64'hDEAD);
          else begin
            check("out_data", out_data, exp_q.pop_front());
            check("out_last", out_last, out_cnt == NM - 1);
            if (out_cnt == NM - 1) exp_done = 1;
            out_cnt++;
          end
        end else begin
          holding = 1; hold_data = out_data; hold_last = out_last;
        end
      end
    end
  end

  initial begin
    int n, g;
    bit f;
    for (int e = 0; e < NM; e++) model_acc[e] = 32'd0;
    out_rand = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_done_err", {done, err, out_last}, 3'b000);
    rst = 1'b1;

    // 1: identity times ramp gives 0..15
    set_identity();
    run_job(0, 0, 0, -1, 0);
    check("pin_t1_c12", model_acc[6], 32'd6);
    check("pin_t1_c33", model_acc[15], 32'd15);

    // 2: signed -1 * 2 summed over K, then unsigned 255 * 2 summed over K
    set_const(8'hFF, 8'h02);
    run_job(1, 0, 0, -1, 0);
    check("pin_t2_signed", model_acc[9], 32'hFFFF_FFF8);
    run_job(0, 0, 0, -1, 0);
    check("pin_t2_unsigned", model_acc[9], 32'd2040);

    // 3: backpressure on both sides
    set_identity();
    out_rand = 1;
    run_job(0, 0, 1, -1, 0);
    out_rand = 0;

    // 4: accumulate across jobs, then clear again
    run_job(0, 1, 0, -1, 0);
    check("pin_t4_acc", model_acc[15], 32'd30);
    run_job(0, 0, 0, -1, 0);
    check("pin_t4_clear", model_acc[15], 32'd15);

    // 5: start pulse during LOAD_B flags err once, job unaffected
    run_job(0, 0, 0, NK + 4, 0);
    check("err_pulses", 64'(err_count), 64'd1);

    // 5b: reset mid-DRAIN, then acc_mode=1 job must see zeroed accumulators
    run_job(0, 1, 0, -1, 5);
    rst = 1'b0;
    exp_q.delete();
    for (int e = 0; e < NM; e++) model_acc[e] = 32'd0;
    @(posedge clk); #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 32'd0);
    rst = 1'b1;
    run_job(0, 1, 0, -1, 0);

    // 6: 16-bit accumulator, 127*127*4 wraps or saturates
    @(posedge clk); #1; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    n = 0; g = 0;
    while (n < 32 && g < 200) begin
      in_valid2 = 1'b1; in_data2 = 8'd127; f = in_ready2;
      @(posedge clk); #1;
      if (f) n++;
      g++;
    end
    in_valid2 = 1'b0;
    n = 0; g = 0;
    while (n < 16 && g < 200) begin
      if (out_valid2) begin
`ifdef TPU_SAT_EN
        check("acc16_data", out_data2, 16'h7FFF);
`else
        check("acc16_data", out_data2, 16'hFC04);
`endif
        check("acc16_last", out_last2, n == 15);
        n++;
      end
      @(posedge clk); #1;
      g++;
    end
    check("acc16_count", 64'(n), 64'd16);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
